rx_downsampler: RTL and testbench
=================================

# rx_downsampler

Receive-side counterpart of the TX upsampler: consumes a high-rate I/Q stream and decimates it by 2/4/8/16 (pick-first or window-average) or passes it 1:1 in bypass. Decimated samples are buffered in a 16-entry FIFO and delivered downstream over a valid/ready handshake. It sits between the RX front-end sample stream and the baseband receive chain.

## Interface
Parameters:
- DW, 16, I/Q sample width (signed two's complement)
- DEPTH, 16, output FIFO depth (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data_i  in  DW  input I sample
- rx_data_q  in  DW  input Q sample
- rx_data_valid  in  1  input sample strobe (no backpressure to source)
- decim_factor  in  2  00=2, 01=4, 10=8, 11=16
- bypass_enable  in  1  1 => 1:1 pass-through
- downsample_mode  in  1  0=pick-first, 1=average
- flush  in  1  discard partial window (FIFO contents kept)
- dn_data_i  out  DW  output I sample
- dn_data_q  out  DW  output Q sample
- dn_data_valid  out  1  FIFO head valid
- dn_data_ready  in  1  downstream accepts head
- sample_count  out  8  output handshakes, wraps 255->0
- buffer_level  out  5  FIFO fill level 0..16
- overflow  out  1  sticky: a decimated sample was dropped

## Operation
- Reset: all outputs 0; phase=0, accumulators=0, FIFO empty, in_stream=0, latched config = factor 2, pick-first, no bypass.
- Stream start: first rx_data_valid with in_stream=0 latches decim_factor, bypass_enable, downsample_mode; that same sample uses the live inputs. Config changes mid-stream are ignored.
- Stream end: in_stream clears when phase=0, FIFO empty, rx_data_valid=0.
- Phase counter 0..F-1 advances on each valid input; wraps to 0 at F-1.
- Pick-first: sample at phase 0 is held; at phase F-1 the held sample is pushed.
- Average: 20-bit signed accumulators per rail; phase 0 loads, others add; at phase F-1 push (acc+sample) >>> log2(F) (arithmetic, floor). No saturation needed.
- Bypass: every valid input pushed directly; phase/accumulators stay 0.
- flush: phase and accumulators cleared same edge; a flush coinciding with a valid input discards that input too. Flush has priority.
- FIFO push when full and no pop in the same cycle: sample dropped, overflow set (cleared only by reset). Push+pop while full: both succeed, level stays 16.
- Pop on dn_data_valid && dn_data_ready; sample_count increments per pop.
- dn_data_i/q show FIFO head while dn_data_valid=1, 0 when empty.

## Timing
- Input completing a window at edge N: sample in FIFO after edge N, dn_data_valid=1 in cycle N+1 (1-cycle latency, both modes and bypass).
- buffer_level updated at the same edge as push/pop; net change -1..+1.
- dn_data_valid depends only on registered state (no combinational path from rx_data_valid or dn_data_ready).
- Async reset mid-window or mid-stream: immediate clear, partial window and FIFO lost.

## Configuration
- RX_DS_AVG_EN defined: average mode available as above.
- Not defined: downsample_mode ignored, always pick-first; accumulators not instantiated.

## Structure
- rx_ds_pkg: factor encoding enum, mode constants, function factor->log2 (1..4), accumulator width constant (DW+4).
- Sub-module rx_ds_fifo: synchronous FWFT FIFO with level, full/empty, simultaneous push/pop.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0, buffer_level=0, overflow=0.
- Factor 4 pick-first, inputs I=10,20,30,40,50,60,70,80 contiguous, ready=1 -> outputs I=10 then 50, each 1 cycle after 4th/8th input.
- Factor 2 average (RX_DS_AVG_EN), I=3,4 and I=-3,-4 -> outputs 3 and -4 (floor).
- Bypass, 5 inputs 1..5 with ready=1 -> 5 outputs 1..5, sample_count=5; config toggled mid-stream has no effect.
- Factor 2, ready=0, 34 inputs -> buffer_level=16, overflow=1; then ready=1 drains 16 samples in order.
- Factor 8, 3 inputs then flush, then 8 inputs of 7 -> single output 7 (flushed partial window not emitted).

Source files
------------

// File: rtl/rx_ds_pkg.sv
// rx_ds_pkg: shared types and helpers for the RX decimator.
//   - decim_e          : decimation factor encoding (00=2, 01=4, 10=8, 11=16)
//   - MODE_PICK/AVG    : downsample_mode encodings
//   - ACC_GUARD_BITS   : growth bits on the averaging accumulators (width DW+4)
//   - decim_log2()     : factor -> log2(factor), 1..4
//   - decim_last()     : factor -> last phase index (factor-1)
//   - stream_state_e   : stream tracking FSM states
package rx_ds_pkg;

    typedef enum logic [1:0] {
        DECIM_2  = 2'b00,
        DECIM_4  = 2'b01,
        DECIM_8  = 2'b10,
        DECIM_16 = 2'b11
    } decim_e;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    // Sixteen samples summed need four extra bits of headroom.
    localparam int ACC_GUARD_BITS = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    function automatic logic [2:0] decim_log2(input decim_e f);
        return {1'b0, f} + 3'd1;
    endfunction

    function automatic logic [3:0] decim_last(input decim_e f);
        logic [3:0] last;
        case (f)
            DECIM_2:  last = 4'd1;
            DECIM_4:  last = 4'd3;
            DECIM_8:  last = 4'd7;
            default:  last = 4'd15;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/rx_ds_fifo.sv
// rx_ds_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n     : clock, async active-low reset
//   push, wdata    : write request and data (ignored when full unless popping)
//   pop            : read request (ignored when empty)
//   rdata          : head entry, forced to 0 while empty
//   full, empty    : status from the registered fill level
//   level          : fill level 0..DEPTH
// Push and pop in the same cycle both succeed even when full.
module rx_ds_fifo
    import rx_ds_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign level   = count;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_downsampler.sv
// rx_downsampler: decimates a high-rate I/Q stream by 2/4/8/16 (pick-first or
// window average) or passes it 1:1 in bypass, buffering results in a FIFO
// drained over a valid/ready handshake.
//   clk, rst_n                   : clock, async active-low reset
//   rx_data_i/q, rx_data_valid   : input samples, no backpressure
//   decim_factor, bypass_enable,
//   downsample_mode              : stream config, latched on stream start
//   flush                        : drop the partial window (FIFO kept)
//   dn_data_i/q, dn_data_valid,
//   dn_data_ready                : FIFO head and handshake
//   sample_count                 : output handshakes, wraps at 256
//   buffer_level                 : FIFO fill level
//   overflow                     : sticky, a decimated sample was dropped
// Build option: define RX_DS_AVG_EN to include window averaging; without it
// downsample_mode is ignored and no accumulators are built.
//
// state     | meaning
// ST_IDLE   | no stream; next accepted sample latches config from live inputs
// ST_STREAM | stream running on latched config; live config ignored
module rx_downsampler
    import rx_ds_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            rx_data_i,
    input  logic [DW-1:0]            rx_data_q,
    input  logic                     rx_data_valid,
    input  logic [1:0]               decim_factor,
    input  logic                     bypass_enable,
    input  logic                     downsample_mode,
    input  logic                     flush,
    output logic [DW-1:0]            dn_data_i,
    output logic [DW-1:0]            dn_data_q,
    output logic                     dn_data_valid,
    input  logic                     dn_data_ready,
    output logic [7:0]               sample_count,
    output logic [$clog2(DEPTH):0]   buffer_level,
    output logic                     overflow
);

    stream_state_e state_q;
    stream_state_e state_d;
    logic          cfg_live;

    decim_e        cfg_factor_q;
    logic          cfg_bypass_q;
    decim_e        eff_factor;
    logic          eff_bypass;

    logic [3:0]    phase_q;
    logic          sample_in;
    logic          start;
    logic          win_last;
    logic          push;
    logic          pop;

    logic [DW-1:0] hold_i_q;
    logic [DW-1:0] hold_q_q;
    logic [DW-1:0] push_i;
    logic [DW-1:0] push_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [2*DW-1:0] fifo_rdata;

    // A flushed input is discarded entirely, so it never starts a stream.
    assign sample_in = rx_data_valid && !flush;
    assign start     = cfg_live && sample_in;

    // ---------------- stream FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_in) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!rx_data_valid && phase_q == 4'd0 && fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_live = (state_q == ST_IDLE);
    end

    // ---------------- configuration ----------------
    // The sample that opens a stream already uses the live config.
    always_comb begin
        eff_factor = cfg_factor_q;
        eff_bypass = cfg_bypass_q;
        if (cfg_live) begin
            eff_factor = decim_e'(decim_factor);
            eff_bypass = bypass_enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_factor_q <= DECIM_2;
            cfg_bypass_q <= 1'b0;
        end else if (start) begin
            cfg_factor_q <= decim_e'(decim_factor);
            cfg_bypass_q <= bypass_enable;
        end
    end

    // ---------------- window phase ----------------
    assign win_last = (phase_q == decim_last(eff_factor));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 4'd0;
        end else if (flush) begin
            phase_q <= 4'd0;
        end else if (sample_in && !eff_bypass) begin
            phase_q <= win_last ? 4'd0 : phase_q + 4'd1;
        end
    end

    // First sample of each window, emitted in pick-first mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_i_q <= '0;
            hold_q_q <= '0;
        end else if (sample_in && !eff_bypass && phase_q == 4'd0) begin
            hold_i_q <= rx_data_i;
            hold_q_q <= rx_data_q;
        end
    end

`ifdef RX_DS_AVG_EN
    localparam int ACC_W = DW + ACC_GUARD_BITS;

    logic                    cfg_mode_q;
    logic                    eff_mode;
    logic signed [ACC_W-1:0] acc_i_q;
    logic signed [ACC_W-1:0] acc_q_q;
    logic signed [ACC_W-1:0] sext_i;
    logic signed [ACC_W-1:0] sext_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic [2:0]              shamt;
    logic [DW-1:0]           avg_i;
    logic [DW-1:0]           avg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_q <= MODE_PICK;
        end else if (start) begin
            cfg_mode_q <= downsample_mode;
        end
    end

    assign eff_mode = cfg_live ? downsample_mode : cfg_mode_q;
    assign sext_i   = {{(ACC_W-DW){rx_data_i[DW-1]}}, rx_data_i};
    assign sext_q   = {{(ACC_W-DW){rx_data_q[DW-1]}}, rx_data_q};
    assign sum_i    = acc_i_q + sext_i;
    assign sum_q    = acc_q_q + sext_q;
    assign shamt    = decim_log2(eff_factor);
    // Arithmetic shift floors toward -inf; the mean always fits in DW bits.
    assign avg_i    = DW'(sum_i >>> shamt);
    assign avg_q    = DW'(sum_q >>> shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (flush) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (sample_in && !eff_bypass && eff_mode == MODE_AVG) begin
            if (phase_q == 4'd0) begin
                acc_i_q <= sext_i;
                acc_q_q <= sext_q;
            end else begin
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = downsample_mode;
`endif

    // ---------------- push path ----------------
    assign push = sample_in && (eff_bypass || win_last);

    always_comb begin
        push_i = hold_i_q;
        push_q = hold_q_q;
        if (eff_bypass) begin
            push_i = rx_data_i;
            push_q = rx_data_q;
        end
`ifdef RX_DS_AVG_EN
        else if (eff_mode == MODE_AVG) begin
            push_i = avg_i;
            push_q = avg_q;
        end
`endif
    end

    // ---------------- output FIFO ----------------
    assign pop = dn_data_valid && dn_data_ready;

    rx_ds_fifo #(
        .W     (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({push_i, push_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (buffer_level)
    );

    // Valid comes from the registered fill level only.
    assign dn_data_valid = !fifo_empty;
    assign dn_data_i     = fifo_rdata[2*DW-1:DW];
    assign dn_data_q     = fifo_rdata[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= 8'd0;
            overflow     <= 1'b0;
        end else begin
            if (pop) begin
                sample_count <= sample_count + 8'd1;
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_downsampler.sv
module tb_rx_downsampler;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_data_i = '0;
    logic [15:0] rx_data_q = '0;
    logic        rx_data_valid = 1'b0;
    logic [1:0]  decim_factor = '0;
    logic        bypass_enable = 1'b0;
    logic        downsample_mode = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] dn_data_i;
    logic [15:0] dn_data_q;
    logic        dn_data_valid;
    logic        dn_data_ready = 1'b0;
    logic [7:0]  sample_count;
    logic [4:0]  buffer_level;
    logic        overflow;

    always #5 clk = ~clk;

    rx_downsampler #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data_i       (rx_data_i),
        .rx_data_q       (rx_data_q),
        .rx_data_valid   (rx_data_valid),
        .decim_factor    (decim_factor),
        .bypass_enable   (bypass_enable),
        .downsample_mode (downsample_mode),
        .flush           (flush),
        .dn_data_i       (dn_data_i),
        .dn_data_q       (dn_data_q),
        .dn_data_valid   (dn_data_valid),
        .dn_data_ready   (dn_data_ready),
        .sample_count    (sample_count),
        .buffer_level    (buffer_level),
        .overflow        (overflow)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a stream is a list of collected window samples, the
    // FIFO is a pair of queues, results are computed with plain arithmetic.
    bit m_in;
    int m_f;
    bit m_byp;
    bit m_avg;
    int win_i[$];
    int win_q[$];
    int fq_i[$];
    int fq_q[$];
    bit m_ovf;
    int m_cnt;

    task automatic model_reset();
        m_in = 0; m_f = 2; m_byp = 0; m_avg = 0;
        win_i.delete(); win_q.delete(); fq_i.delete(); fq_q.delete();
        m_ovf = 0; m_cnt = 0;
    endtask

    function automatic int floor_mean(input int s[$], input int n);
        int sum = 0;
        int r;
        foreach (s[k]) sum += s[k];
        r = sum / n;
        if ((sum % n) != 0 && sum < 0) r -= 1;
        return r;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic drive_cycle(input bit v, input int di, input int dq, input bit fl,
                               input bit rdy, input logic [1:0] fac, input bit byp,
                               input bit mode);
        bit pop, end_c, push;
        int pi, pq;
        rx_data_valid = v; rx_data_i = di[15:0]; rx_data_q = dq[15:0];
        flush = fl; dn_data_ready = rdy;
        decim_factor = fac; bypass_enable = byp; downsample_mode = mode;
        @(posedge clk);
        pop   = (fq_i.size() > 0) && rdy;
        end_c = m_in && !v && win_i.size() == 0 && fq_i.size() == 0;
        push  = 0; pi = 0; pq = 0;
        if (fl) begin
            win_i.delete(); win_q.delete();
        end else if (v) begin
            if (!m_in) begin
                m_in = 1; m_f = 2 << fac; m_byp = byp;
`ifdef RX_DS_AVG_EN
                m_avg = mode;
`else
                m_avg = 0;
`endif
            end
            if (m_byp) begin
                push = 1; pi = di; pq = dq;
            end else begin
                win_i.push_back(di); win_q.push_back(dq);
                if (win_i.size() == m_f) begin
                    push = 1;
                    if (m_avg) begin
                        pi = floor_mean(win_i, m_f); pq = floor_mean(win_q, m_f);
                    end else begin
                        pi = win_i[0]; pq = win_q[0];
                    end
                    win_i.delete(); win_q.delete();
                end
            end
        end
        if (end_c) m_in = 0;
        if (push && fq_i.size() == DEPTH && !pop) m_ovf = 1;
        if (pop) begin
            void'(fq_i.pop_front()); void'(fq_q.pop_front()); m_cnt++;
        end
        if (push && !(m_ovf && fq_i.size() == DEPTH)) begin
            fq_i.push_back(pi); fq_q.push_back(pq);
        end
        #1;
    endtask

    // Flush any partial window and drain until the stream has ended.
    task automatic go_idle();
        int n = 0;
        drive_cycle(0, 0, 0, 1, 1, 2'b00, 0, 0);
        while ((m_in || fq_i.size() > 0) && n < 40) begin
            drive_cycle(0, 0, 0, 0, 1, 2'b00, 0, 0);
            n++;
        end
        checks++;
        if (m_in || fq_i.size() > 0) begin
            failures++;
            $display("FAIL go_idle timeout: fifo=%0d in_stream=%0d required empty/idle", fq_i.size(), m_in);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({dn_data_valid, dn_data_i, dn_data_q, sample_count, buffer_level, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_init: valid=%0b i=%0h q=%0h cnt=%0d lvl=%0d ovf=%0b required all 0",
                     dn_data_valid, dn_data_i, dn_data_q, sample_count, buffer_level, overflow);
        end
        for (int k = 0; k < 5; k++) drive_cycle(1, k + 1, rnd16(), 0, 0, 2'b00, 0, 0);
        checks++;
        if (buffer_level !== 5'd2 || dn_data_i !== 16'd1) begin
            failures++;
            $display("FAIL reset_prefill: lvl=%0d i=%0d required lvl=2 i=1", buffer_level, dn_data_i);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({dn_data_valid, dn_data_i, dn_data_q, sample_count, buffer_level, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_async: valid=%0b i=%0h q=%0h cnt=%0d lvl=%0d ovf=%0b required all 0",
                     dn_data_valid, dn_data_i, dn_data_q, sample_count, buffer_level, overflow);
        end
        model_reset();
        rx_data_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        logic [15:0] e;
        go_idle();
        for (int k = 0; k < 5; k++) begin
            // config toggled after the first sample must not take effect
            if (k == 0) drive_cycle(1, k + 1, 100 + k, 0, 1, 2'b00, 1, 0);
            else        drive_cycle(1, k + 1, 100 + k, 0, 1, 2'b11, 0, 1);
            e = 16'(k + 1);
            checks++;
            if (dn_data_valid !== 1'b1 || dn_data_i !== e || buffer_level !== 5'd1) begin
                failures++;
                $display("FAIL bypass_out%0d: valid=%0b i=%0d lvl=%0d required valid=1 i=%0d lvl=1",
                         k, dn_data_valid, dn_data_i, buffer_level, e);
            end
        end
        drive_cycle(0, 0, 0, 0, 1, 2'b00, 0, 0);
        checks++;
        if (sample_count !== 8'd5 || dn_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_count: cnt=%0d valid=%0b required cnt=5 valid=0", sample_count, dn_data_valid);
        end
    endtask

    task automatic test_pick_first_f4();
        int q0, q4;
        logic [15:0] ei, eq;
        go_idle();
        for (int k = 0; k < 8; k++) begin
            int qv = rnd16();
            if (k == 0) q0 = qv;
            if (k == 4) q4 = qv;
            drive_cycle(1, (k + 1) * 10, qv, 0, 1, 2'b01, 0, 0);
            checks++;
            if (k == 3 || k == 7) begin
                ei = (k == 3) ? 16'd10 : 16'd50;
                eq = (k == 3) ? q0[15:0] : q4[15:0];
                if (dn_data_valid !== 1'b1 || dn_data_i !== ei || dn_data_q !== eq) begin
                    failures++;
                    $display("FAIL pick_f4_out%0d: valid=%0b i=%0d q=%0h required valid=1 i=%0d q=%0h",
                             k, dn_data_valid, dn_data_i, dn_data_q, ei, eq);
                end
            end else if (dn_data_valid !== 1'b0) begin
                failures++;
                $display("FAIL pick_f4_idle%0d: valid=%0b required 0", k, dn_data_valid);
            end
        end
    endtask

    task automatic test_average();
        int vals[4] = '{3, 4, -3, -4};
        logic [15:0] e;
        go_idle();
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1, vals[k], -vals[k], 0, 1, 2'b00, 0, 1);
            if (k == 1 || k == 3) begin
`ifdef RX_DS_AVG_EN
                e = (k == 1) ? 16'd3 : 16'hFFFC;
`else
                e = (k == 1) ? 16'd3 : 16'hFFFD;
`endif
                checks++;
                if (dn_data_valid !== 1'b1 || dn_data_i !== e) begin
                    failures++;
                    $display("FAIL average_out%0d: valid=%0b i=%0h required valid=1 i=%0h",
                             k, dn_data_valid, dn_data_i, e);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] e;
        go_idle();
        for (int k = 0; k < 34; k++) drive_cycle(1, 100 + k, rnd16(), 0, 0, 2'b00, 0, 0);
        checks++;
        if (buffer_level !== 5'd16 || overflow !== 1'b1 || dn_data_i !== 16'd100) begin
            failures++;
            $display("FAIL overflow_full: lvl=%0d ovf=%0b head=%0d required lvl=16 ovf=1 head=100",
                     buffer_level, overflow, dn_data_i);
        end
        for (int j = 0; j < 16; j++) begin
            drive_cycle(0, 0, 0, 0, 1, 2'b00, 0, 0);
            e = 16'(100 + 2 * (j + 1));
            checks++;
            if (j < 15) begin
                if (dn_data_valid !== 1'b1 || dn_data_i !== e || buffer_level !== 5'(15 - j)) begin
                    failures++;
                    $display("FAIL overflow_drain%0d: valid=%0b i=%0d lvl=%0d required valid=1 i=%0d lvl=%0d",
                             j, dn_data_valid, dn_data_i, buffer_level, e, 15 - j);
                end
            end else if (dn_data_valid !== 1'b0 || buffer_level !== 5'd0 || overflow !== 1'b1) begin
                failures++;
                $display("FAIL overflow_empty: valid=%0b lvl=%0d ovf=%0b required valid=0 lvl=0 ovf=1",
                         dn_data_valid, buffer_level, overflow);
            end
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        go_idle();
        for (int k = 0; k < 3; k++) drive_cycle(1, rnd16(), rnd16(), 0, 1, 2'b10, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 2'b10, 0, 0);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive_cycle(1, 7, 7, 0, 1, 2'b10, 0, 0);
            else       drive_cycle(0, 0, 0, 0, 1, 2'b10, 0, 0);
            if (dn_data_valid === 1'b1) begin
                seen++;
                checks++;
                if (dn_data_i !== 16'd7 || dn_data_q !== 16'd7 || k != 7) begin
                    failures++;
                    $display("FAIL flush_out: i=%0d q=%0d at %0d required i=7 q=7 at 7", dn_data_i, dn_data_q, k);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL flush_count: outputs=%0d required 1", seen);
        end
    endtask

    task automatic test_random();
        logic [15:0] ei, eq;
        go_idle();
        for (int c = 0; c < 1500; c++) begin
            bit v   = ($urandom_range(0, 99) < 70);
            bit rdy = ($urandom_range(0, 99) < 55);
            bit fl  = ($urandom_range(0, 99) < 3);
            bit byp = ($urandom_range(0, 99) < 20);
            if (c % 300 > 270) v = 0;
            drive_cycle(v, rnd16(), rnd16(), fl, rdy, 2'($urandom_range(0, 3)), byp,
                        1'($urandom_range(0, 1)));
            ei = (fq_i.size() > 0) ? fq_i[0][15:0] : 16'd0;
            eq = (fq_q.size() > 0) ? fq_q[0][15:0] : 16'd0;
            checks++;
            if (dn_data_valid !== (fq_i.size() > 0) || dn_data_i !== ei || dn_data_q !== eq ||
                buffer_level !== 5'(fq_i.size()) || overflow !== m_ovf || sample_count !== 8'(m_cnt)) begin
                failures++;
                $display("FAIL random_c%0d: valid=%0b i=%0h q=%0h lvl=%0d ovf=%0b cnt=%0d required valid=%0b i=%0h q=%0h lvl=%0d ovf=%0b cnt=%0d",
                         c, dn_data_valid, dn_data_i, dn_data_q, buffer_level, overflow, sample_count,
                         fq_i.size() > 0, ei, eq, fq_i.size(), m_ovf, m_cnt % 256);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_pick_first_f4();
        test_average();
        test_overflow();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
